// File: rtl/ov7670_stream_gen_if.sv
// Pixel stream handshake between an RGB444 pixel source and the OV7670 bus emulator.
interface ov7670_stream_gen_if;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: emulates the OV7670 camera output bus (VSYNC/HREF/8-bit RGB444 xR-GB bytes),
// one byte per clk, fed from a valid/ready pixel stream or from built-in colour bars.
module ov7670_stream_gen #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic               pattern_en_i,
    ov7670_stream_gen_if.slave pix_if,
    output logic               vsync_o,
    output logic               href_o,
    output logic [7:0]         d_o,
    output logic               frame_done_o,
    output logic               underrun_o
);

    localparam int LINE      = 2 * H_ACTIVE + H_BLANK;
    localparam int ACT_BYTES = 2 * H_ACTIVE;
    localparam int BAR_W     = H_ACTIVE / 8;
    localparam int CW        = $clog2(LINE);
    localparam int LW        = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
    localparam int BW        = $clog2(BAR_W + 1);

    typedef enum logic [2:0] {IDLE, VS, VB, ACT, VF} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [LW-1:0]   line_q, line_d;
    logic [BW-1:0]   barPix_q, barPix_d;
    logic [2:0]      bar_q, bar_d;
    logic            pattern_q, pattern_d;
    logic [11:0]     pixel_q, pixel_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      d_q, d_d;
    logic            frameDone_q, frameDone_d;
    logic            underrun_q, underrun_d;

    int              phaseLines;
    logic            endOfLine;
    logic            lastLine;
    logic            frameEnd;
    logic            actByte;
    logic            byteSel;
    logic            firstVs;
    logic [11:0]     barColour;
    logic [11:0]     srcPixel;

    // Frame position: state plus column/line counters, and the colour-bar position along the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= '0;
            line_q   <= '0;
            barPix_q <= '0;
            bar_q    <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            line_q   <= line_d;
            barPix_q <= barPix_d;
            bar_q    <= bar_d;
        end
    end

    // Walk the frame line by line; enable is only looked at in IDLE and on the last VF cycle.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        line_d   = line_q;
        barPix_d = barPix_q;
        bar_d    = bar_q;

        case (state_q)
            VS:      phaseLines = VSYNC_LINES;
            VB:      phaseLines = V_BACK;
            ACT:     phaseLines = V_ACTIVE;
            VF:      phaseLines = V_FRONT;
            default: phaseLines = 1;
        endcase

        endOfLine = (col_q == CW'(LINE - 1));
        lastLine  = (line_q == LW'(phaseLines - 1));
        frameEnd  = (state_q == VF) && endOfLine && lastLine;
        actByte   = (state_q == ACT) && (col_q < CW'(ACT_BYTES));

        if (state_q == IDLE) begin
            if (enable_i) begin
                state_d = VS;
                col_d   = '0;
                line_d  = '0;
            end
        end else begin
            col_d = endOfLine ? '0 : col_q + 1'b1;
            if (endOfLine) begin
                if (lastLine) begin
                    line_d = '0;
                    case (state_q)
                        VS:      state_d = VB;
                        VB:      state_d = ACT;
                        ACT:     state_d = VF;
                        VF:      state_d = enable_i ? VS : IDLE;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
        end

        if (actByte && col_q[0]) begin
            if (barPix_q == BW'(BAR_W - 1)) begin
                barPix_d = '0;
                bar_d    = bar_q + 3'd1;
            end else begin
                barPix_d = barPix_q + 1'b1;
            end
        end
        if (endOfLine || state_q != ACT) begin
            barPix_d = '0;
            bar_d    = '0;
        end
    end

    // Bus bytes, pixel handshake and status derived from the current frame position.
    always_comb begin
        byteSel = col_q[0];
        firstVs = (state_q == VS) && (col_q == '0) && (line_q == '0);

        case (bar_q)
            3'd0:    barColour = 12'hFFF;
            3'd1:    barColour = 12'hFF0;
            3'd2:    barColour = 12'h0FF;
            3'd3:    barColour = 12'h0F0;
            3'd4:    barColour = 12'hF0F;
            3'd5:    barColour = 12'hF00;
            3'd6:    barColour = 12'h00F;
            default: barColour = 12'h000;
        endcase

        srcPixel = pattern_q ? barColour : (pix_if.pix_valid ? pix_if.pix_data : 12'h000);

        pix_if.pix_ready = actByte && !byteSel && !pattern_q;

        pixel_d = pixel_q;
        if (actByte && !byteSel) begin
            pixel_d = srcPixel;
        end

        vsync_d     = (state_q == VS);
        href_d      = actByte;
        frameDone_d = frameEnd;

        d_d = 8'h00;
        if (actByte) begin
            d_d = byteSel ? pixel_q[7:0] : {4'h0, srcPixel[11:8]};
        end

        pattern_d = firstVs ? pattern_en_i : pattern_q;

        underrun_d = underrun_q;
        if (actByte && !byteSel && !pattern_q && !pix_if.pix_valid) begin
            underrun_d = 1'b1;
        end
        if (firstVs) begin
            underrun_d = 1'b0;
        end
    end

    // Register every bus output so it trails the frame position by exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q   <= 1'b0;
            pixel_q     <= 12'h000;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            d_q         <= 8'h00;
            frameDone_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            pixel_q     <= pixel_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            d_q         <= d_d;
            frameDone_q <= frameDone_d;
            underrun_q  <= underrun_d;
        end
    end

    assign vsync_o      = vsync_q;
    assign href_o       = href_q;
    assign d_o          = d_q;
    assign frame_done_o = frameDone_q;
    assign underrun_o   = underrun_q;

endmodule
